// File: rtl/stream_pkg.sv
// Shared stream helpers: width calculation and lane keep-mask generation.
package stream_pkg;

  // Largest lane count any stream block in this slice is built for.
  localparam int MAX_RATIO = 16;
  // Bits needed to index MAX_RATIO lanes.
  localparam int MAX_CW = 4;

  // Ceiling log2 with a floor of 1 so a counter never collapses to zero width.
  function automatic int width_of(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

  // Lanes 0..cnt set, all higher lanes clear.
  function automatic logic [MAX_RATIO-1:0] keep_mask(input logic [MAX_CW-1:0] cnt);
    logic [MAX_RATIO-1:0] m;
    for (int i = 0; i < MAX_RATIO; i++) begin
      m[i] = (i <= int'(cnt));
    end
    return m;
  endfunction

endpackage

// File: rtl/stream_width_packer.sv
// Valid/ready upsizer: packs RATIO consecutive IW-bit beats into one
// IW*RATIO-bit word, little-endian (first beat in lane 0). A beat with
// i_last closes the word early; o_keep marks which lanes carry data.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// Once valid is raised, data/last are held until the transfer. o_ready
// is !o_valid || i_ready, so it depends combinationally on i_ready only.
module stream_width_packer
  import stream_pkg::*;
#(
  parameter int   IW           = 8,
  parameter int   RATIO        = 4,
  parameter logic OPT_LOWPOWER = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [IW-1:0]       i_data,
  input  logic                i_last,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [IW*RATIO-1:0] o_data,
  output logic [RATIO-1:0]    o_keep,
  output logic                o_last
);

  localparam int OW = IW * RATIO;
  localparam int CW = width_of(RATIO);

  // Lane counter: index of the lane the next accepted beat lands in.
  logic [CW-1:0] cnt;
  // Beats of the word under construction; lanes at and above cnt are zero.
  logic [OW-1:0] acc;

  logic                 accept;
  logic                 last_lane;
  logic                 complete;
  logic [MAX_RATIO-1:0] full_mask;
  logic [RATIO-1:0]     lane_keep;
  logic [OW-1:0]        lane_bits;
  logic [OW-1:0]        merged;
  logic [OW-1:0]        word_next;

  // The output register can take a new word if it is empty or draining now.
  assign o_ready   = !o_valid || i_ready;
  assign accept    = i_valid && o_ready;
  assign last_lane = (cnt == CW'(RATIO - 1));
  assign complete  = accept && (last_lane || i_last);

  // Keep mask for a word closing at lane cnt.
  always_comb begin
    full_mask = keep_mask(MAX_CW'(cnt));
    lane_keep = full_mask[RATIO-1:0];
  end

  // Accumulator with the incoming beat dropped into lane cnt, and the
  // same word with lanes above cnt forced to zero for emission.
  always_comb begin
    merged    = acc;
    lane_bits = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (k == int'(cnt)) begin
        merged[k*IW +: IW] = i_data;
      end
      lane_bits[k*IW +: IW] = {IW{lane_keep[k]}};
    end
    word_next = merged & lane_bits;
  end

  generate
    if (RATIO < MAX_RATIO) begin : g_mask_tail
      // Lanes beyond RATIO do not exist in this instance.
      logic unused_mask_tail;
      assign unused_mask_tail = |full_mask[MAX_RATIO-1:RATIO];
    end
  endgenerate

  // Lane counter and accumulator: fill on each accepted beat, clear on completion.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt <= '0;
      acc <= '0;
    end else if (complete) begin
      cnt <= '0;
      acc <= '0;
    end else if (accept) begin
      cnt <= cnt + CW'(1);
      acc <= merged;
    end
  end

  // Output word register: load on completion, drop valid once drained.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_keep  <= '0;
      o_last  <= 1'b0;
    end else if (complete) begin
      o_valid <= 1'b1;
      o_data  <= word_next;
      o_keep  <= lane_keep;
      o_last  <= i_last;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
      if (OPT_LOWPOWER) begin
        o_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_stream_width_packer.sv
// Directed and randomised bench for stream_width_packer (IW=8, RATIO=4).
module tb_stream_width_packer;

  localparam int IW      = 8;
  localparam int RATIO   = 4;
  localparam int OW      = IW * RATIO;
  localparam int TIMEOUT = 200;

  logic          i_clk;
  logic          i_reset;
  logic          i_valid;
  logic          o_ready;
  logic [IW-1:0] i_data;
  logic          i_last;
  logic          o_valid;
  logic          i_ready;
  logic [OW-1:0] o_data;
  logic [RATIO-1:0] o_keep;
  logic          o_last;

  int tests_run    = 0;
  int tests_failed = 0;
  int stall_cycles = 0;

  logic [OW-1:0]    exp_q[$];
  logic [RATIO-1:0] exp_keep_q[$];
  logic             exp_last_q[$];

  // model state for the random phase
  int               m_lane = 0;
  logic [OW-1:0]    m_word = '0;
  logic [RATIO-1:0] m_keep = '0;

  stream_width_packer #(
    .IW(IW),
    .RATIO(RATIO),
    .OPT_LOWPOWER(1'b0)
  ) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_data (i_data),
    .i_last (i_last),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_data (o_data),
    .o_keep (o_keep),
    .o_last (o_last)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input logic [OW-1:0] d, input logic [RATIO-1:0] k, input logic l);
    exp_q.push_back(d);
    exp_keep_q.push_back(k);
    exp_last_q.push_back(l);
  endtask

  // drive one beat and hold it until accepted
  task automatic send_beat(input logic [IW-1:0] d, input logic l);
    int waited;
    waited  = 0;
    i_valid = 1'b1;
    i_data  = d;
    i_last  = l;
    @(negedge i_clk);
    while (!o_ready && waited < TIMEOUT) begin
      waited++;
      stall_cycles++;
      @(negedge i_clk);
    end
    if (waited >= TIMEOUT) check("send_accept", {63'd0, o_ready}, 64'd1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < TIMEOUT) begin
      @(posedge i_clk);
      #1;
      c++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic model_beat(input logic [IW-1:0] d, input logic l);
    m_word[m_lane*IW +: IW] = d;
    m_keep[m_lane] = 1'b1;
    if (l || m_lane == RATIO - 1) begin
      expect_word(m_word, m_keep, l);
      m_word = '0;
      m_keep = '0;
      m_lane = 0;
    end else begin
      m_lane++;
    end
  endtask

  // scoreboard: every word transferred downstream must match the queue head
  always @(negedge i_clk) begin
    if (!i_reset && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_word", 64'(exp_q.size()), 64'd1);
      end else begin
        check("sb_data", 64'(o_data), 64'(exp_q.pop_front()));
        check("sb_keep", 64'(o_keep), 64'(exp_keep_q.pop_front()));
        check("sb_last", {63'd0, o_last}, {63'd0, exp_last_q.pop_front()});
      end
    end
  end

  initial begin
    int issued;
    int accepted;
    int cycles;
    logic acc_now;

    i_reset = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_last  = 1'b0;
    i_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_reset = 1'b0;

    // reset state
    check("rst_o_valid", {63'd0, o_valid}, 64'd0);
    check("rst_o_data",  64'(o_data), 64'd0);
    check("rst_o_keep",  64'(o_keep), 64'd0);
    check("rst_o_last",  {63'd0, o_last}, 64'd0);
    check("rst_o_ready", {63'd0, o_ready}, 64'd1);

    // full word closed by last on lane 3
    expect_word(32'h44332211, 4'hF, 1'b1);
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b0);
    check("full_no_early_valid", {63'd0, o_valid}, 64'd0);
    send_beat(8'h44, 1'b1);
    check("full_valid", {63'd0, o_valid}, 64'd1);
    check("full_data",  64'(o_data), 64'h44332211);
    check("full_keep",  64'(o_keep), 64'hF);
    check("full_last",  {63'd0, o_last}, 64'd1);
    wait_drain();

    // short packet
    expect_word(32'h0000BBAA, 4'h3, 1'b1);
    send_beat(8'hAA, 1'b0);
    send_beat(8'hBB, 1'b1);
    check("short_data", 64'(o_data), 64'h0000BBAA);
    check("short_keep", 64'(o_keep), 64'h3);
    wait_drain();

    // two-word packet, continuous ready
    stall_cycles = 0;
    expect_word(32'h04030201, 4'hF, 1'b0);
    expect_word(32'h08070605, 4'hF, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      send_beat(IW'(i), (i == 8));
    end
    check("long_no_stall", 64'(stall_cycles), 64'd0);
    wait_drain();

    // output stall with a beat waiting
    i_ready = 1'b0;
    expect_word(32'hC4C3C2C1, 4'hF, 1'b1);
    expect_word(32'h000000D1, 4'h1, 1'b1);
    send_beat(8'hC1, 1'b0);
    send_beat(8'hC2, 1'b0);
    send_beat(8'hC3, 1'b0);
    send_beat(8'hC4, 1'b1);
    i_valid = 1'b1;
    i_data  = 8'hD1;
    i_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      check("stall_o_ready", {63'd0, o_ready}, 64'd0);
      check("stall_data", 64'(o_data), 64'hC4C3C2C1);
      check("stall_keep", 64'(o_keep), 64'hF);
      check("stall_last", {63'd0, o_last}, 64'd1);
    end
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    send_beat(8'hD1, 1'b1);
    check("b2b_valid", {63'd0, o_valid}, 64'd1);
    check("b2b_data", 64'(o_data), 64'h000000D1);
    wait_drain();

    // reset mid-word
    send_beat(8'h10, 1'b0);
    send_beat(8'h20, 1'b0);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    check("midrst_o_valid", {63'd0, o_valid}, 64'd0);
    check("midrst_o_data", 64'(o_data), 64'd0);
    expect_word(32'h0000005A, 4'h1, 1'b1);
    send_beat(8'h5A, 1'b1);
    check("midrst_data", 64'(o_data), 64'h0000005A);
    check("midrst_keep", 64'(o_keep), 64'h1);
    wait_drain();

    // random valid/ready, random packet boundaries
    issued   = 0;
    accepted = 0;
    cycles   = 0;
    while (accepted < 1000 && cycles < 20000) begin
      @(negedge i_clk);
      acc_now = i_valid && o_ready;
      @(posedge i_clk);
      #1;
      cycles++;
      if (acc_now) begin
        model_beat(i_data, i_last);
        accepted++;
        i_valid = 1'b0;
        i_last  = 1'b0;
      end
      i_ready = 1'($urandom_range(0, 1));
      if (!i_valid && issued < 1000 && $urandom_range(0, 1) == 1) begin
        i_valid = 1'b1;
        i_data  = IW'($urandom_range(0, 255));
        i_last  = ($urandom_range(0, 4) == 0) || (issued == 999);
        issued++;
      end
    end
    check("rand_beats_accepted", 64'(accepted), 64'd1000);
    i_ready = 1'b1;
    wait_drain();
    repeat (3) @(posedge i_clk);
    #1;
    check("final_idle", {63'd0, o_valid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
